// File: rtl/debounce_multi.sv
// debounce_multi
//
// Multi-channel switch/button debouncer. Every channel has its own input
// synchroniser, a four-state debounce FSM with a down-counter, registered
// rise/fall edge ticks and an optional long-press detector. Channels share
// only clock, reset and the timing parameters.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-low reset
//   sw         raw asynchronous switch inputs, bit i = channel i
//   db_level   debounced level per channel (registered)
//   rise_tick  one-cycle pulse on the first cycle db_level is 1 after a press
//   fall_tick  one-cycle pulse on the first cycle db_level is 0 after a release
//   long_tick  one-cycle pulse when a press has lasted LONG_CYCLES cycles
//   dbg_state  per-channel FSM state, 2 bits per channel (channel i at [2i+1:2i])
//              encoding: 00 ZERO, 01 WAIT1, 10 ONE, 11 WAIT0
//
// The outputs carry no handshake: ticks are fire-and-forget single-cycle
// pulses and db_level is a plain registered level.

module debounce_multi #(
  parameter int CHANNELS    = 4,
  parameter int DB_CYCLES   = 1000000,
  parameter int SYNC_STAGES = 2,
  parameter int LONG_CYCLES = 50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   sw,
  output logic [CHANNELS-1:0]   db_level,
  output logic [CHANNELS-1:0]   rise_tick,
  output logic [CHANNELS-1:0]   fall_tick,
  output logic [CHANNELS-1:0]   long_tick,
  output logic [2*CHANNELS-1:0] dbg_state
);

  localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int LONG_W = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;

  localparam logic [DB_W-1:0]   DB_LOAD  = DB_W'(DB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);

  typedef enum logic [1:0] {
    ST_ZERO  = 2'b00,
    ST_WAIT1 = 2'b01,
    ST_ONE   = 2'b10,
    ST_WAIT0 = 2'b11
  } state_t;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch

    // Input synchroniser; only the last stage feeds the FSM.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge clk) begin
      if (!reset) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], sw[i]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    state_t          state_q, state_d;
    logic [DB_W-1:0] cnt_q, cnt_d;
    logic            lvl_now;
    logic            enter_one;
    logic            enter_zero;
    logic            db_q, rise_q, fall_q;

    // State register
    always_ff @(posedge clk) begin
      if (!reset) begin
        state_q <= ST_ZERO;
      end else begin
        state_q <= state_d;
      end
    end

    // Next-state logic
    always_comb begin
      state_d = state_q;
      case (state_q)
        ST_ZERO:  if (s) state_d = ST_WAIT1;
        ST_WAIT1: begin
          if (!s)                state_d = ST_ZERO;
          else if (cnt_q == '0)  state_d = ST_ONE;
        end
        ST_ONE:   if (!s) state_d = ST_WAIT0;
        ST_WAIT0: begin
          if (s)                 state_d = ST_ONE;
          else if (cnt_q == '0)  state_d = ST_ZERO;
        end
        default:  state_d = ST_ZERO;
      endcase
    end

    // Output / datapath logic: debounce counter and derived level.
    // The counter is loaded when a wait state is entered and counts down
    // while the synchronised input agrees with the pending level.
    always_comb begin
      cnt_d = cnt_q;
      case (state_q)
        ST_ZERO:  if (s) cnt_d = DB_LOAD;
        ST_WAIT1: if (s && cnt_q != '0) cnt_d = cnt_q - DB_W'(1);
        ST_ONE:   if (!s) cnt_d = DB_LOAD;
        ST_WAIT0: if (!s && cnt_q != '0) cnt_d = cnt_q - DB_W'(1);
        default:  cnt_d = '0;
      endcase
    end

    assign lvl_now    = (state_q == ST_ONE) || (state_q == ST_WAIT0);
    // Aborted waits (WAIT0->ONE, WAIT1->ZERO) are deliberately not entries.
    assign enter_one  = (state_q == ST_WAIT1) && (state_d == ST_ONE);
    assign enter_zero = (state_q == ST_WAIT0) && (state_d == ST_ZERO);

    // Level and edge ticks are registered from the state, so a tick always
    // coincides with the first cycle of the new db_level.
    always_ff @(posedge clk) begin
      if (!reset) begin
        cnt_q  <= '0;
        db_q   <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        db_q   <= lvl_now;
        rise_q <= lvl_now & ~db_q;
        fall_q <= ~lvl_now & db_q;
      end
    end

    assign db_level[i]         = db_q;
    assign rise_tick[i]        = rise_q;
    assign fall_tick[i]        = fall_q;
    assign dbg_state[2*i +: 2] = state_q;

    if (LONG_CYCLES > 0) begin : g_long
      logic [LONG_W-1:0] long_q, long_d;
      logic              long_hit;
      logic              long_tick_q;

      // Counts every cycle the debounced level is high, including WAIT0,
      // and saturates so the tick fires exactly once per press.
      always_comb begin
        long_d   = long_q;
        long_hit = 1'b0;
        if (enter_one || enter_zero) begin
          long_d = '0;
        end else if (db_q && long_q != LONG_MAX) begin
          long_d   = long_q + LONG_W'(1);
          long_hit = (long_q == LONG_MAX - LONG_W'(1));
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          long_q      <= '0;
          long_tick_q <= 1'b0;
        end else begin
          long_q      <= long_d;
          long_tick_q <= long_hit;
        end
      end

      assign long_tick[i] = long_tick_q;
    end else begin : g_no_long
      assign long_tick[i] = 1'b0;
    end

  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed testbench for debounce_multi with CHANNELS=2, DB_CYCLES=8,
// SYNC_STAGES=2, LONG_CYCLES=20. Each step drives reset/sw at a falling
// edge, lets one rising edge happen, and samples at the next falling edge.
// Step index k counts the rising edges of a scenario starting at 0; a level
// first sampled at edge k shows up in db_level/rise_tick at edge k+11.

module tb_debounce_multi;

  localparam int CH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [CH-1:0] sw;
  logic [CH-1:0] db_level, rise_tick, fall_tick, long_tick;
  logic [2*CH-1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  debounce_multi #(
    .CHANNELS    (CH),
    .DB_CYCLES   (8),
    .SYNC_STAGES (2),
    .LONG_CYCLES (20)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .db_level  (db_level),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .long_tick (long_tick),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Checker
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%b expected=%b (lvl,rise,fall,long)", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pack(input logic [1:0] l, input logic [1:0] r,
                                      input logic [1:0] f, input logic [1:0] g);
    return {l, r, f, g};
  endfunction

  function automatic logic [7:0] outs();
    return {db_level, rise_tick, fall_tick, long_tick};
  endfunction

  // Driver: apply inputs, one rising edge, sample at falling edge.
  task automatic step(input logic rst_v, input logic [1:0] sw_v);
    reset = rst_v;
    sw    = sw_v;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic       b;
    logic [1:0] l, r, f, g;

    reset = 1'b0;
    sw    = '0;
    @(negedge clk);

    // Reset state
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 2'b00);
      check($sformatf("reset k=%0d", k), outs(), 8'h00);
    end
    check("reset_state", {4'b0, dbg_state}, 8'h00);

    // Idle for 50 cycles
    for (int k = 0; k < 50; k++) begin
      step(1'b1, 2'b00);
      check($sformatf("idle k=%0d", k), outs(), 8'h00);
    end

    // Clean press on ch0 held through k=15, then released
    for (int k = 0; k <= 35; k++) begin
      b = (k <= 15);
      step(1'b1, {1'b0, b});
      l = {1'b0, 1'(k >= 11 && k < 27)};
      r = {1'b0, 1'(k == 11)};
      f = {1'b0, 1'(k == 27)};
      g = 2'b00;
      check($sformatf("press0 k=%0d", k), outs(), pack(l, r, f, g));
    end

    // Bouncy press on ch0: high 5, low 1, high 5, low -> nothing
    for (int k = 0; k <= 30; k++) begin
      b = (k <= 4) || (k >= 6 && k <= 10);
      step(1'b1, {1'b0, b});
      check($sformatf("bounce_press k=%0d", k), outs(), 8'h00);
    end

    // Solid press, then bouncy release (low 5, high 1, low 5, high), final
    // release at k=35. The WAIT0 aborts keep the long counter running.
    for (int k = 0; k <= 55; k++) begin
      b = (k <= 13) || (k == 19) || (k >= 25 && k <= 34);
      step(1'b1, {1'b0, b});
      l = {1'b0, 1'(k >= 11 && k < 46)};
      r = {1'b0, 1'(k == 11)};
      f = {1'b0, 1'(k == 46)};
      g = {1'b0, 1'(k == 31)};
      check($sformatf("bounce_release k=%0d", k), outs(), pack(l, r, f, g));
    end

    // Long press on ch1 held 40 cycles
    for (int k = 0; k <= 60; k++) begin
      b = (k <= 39);
      step(1'b1, {b, 1'b0});
      l = {1'(k >= 11 && k < 51), 1'b0};
      r = {1'(k == 11), 1'b0};
      f = {1'(k == 51), 1'b0};
      g = {1'(k == 31), 1'b0};
      check($sformatf("long1 k=%0d", k), outs(), pack(l, r, f, g));
    end

    // Simultaneous press of both channels
    for (int k = 0; k <= 35; k++) begin
      b = (k <= 14);
      step(1'b1, {b, b});
      l = {2{1'(k >= 11 && k < 26)}};
      r = {2{1'(k == 11)}};
      f = {2{1'(k == 26)}};
      g = 2'b00;
      check($sformatf("both k=%0d", k), outs(), pack(l, r, f, g));
    end

    // Reset during WAIT1 with sw[0] held high; first non-reset edge is k=8
    for (int k = 0; k <= 30; k++) begin
      b = !(k >= 5 && k <= 7);
      step(b, 2'b01);
      l = {1'b0, 1'(k >= 19)};
      r = {1'b0, 1'(k == 19)};
      check($sformatf("mid_reset k=%0d", k), outs(), pack(l, r, 2'b00, 2'b00));
      if (k == 4) check("wait1_state", {4'b0, dbg_state}, 8'h01);
      if (k == 7) check("reset_clears_state", {4'b0, dbg_state}, 8'h00);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
